// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Turns hazard requests (load-use, multi-cycle EX ops, MEM bus wait,
// exceptions) into hold/bubble/clear controls for the pipeline registers
// and owns the EX occupancy counter for multi-cycle ops.
// Optional feature macro: PIPE_CTRL_PERF_EN adds stall/flush event counters.
module pipe_ctrl #(
    parameter int MULTI_CYCLES = 36,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_stall_req,
    input  logic       ex_multi_start,
    input  logic       mem_stall_req,
    input  logic       except_req,
    output logic [3:0] stall,
    output logic       bubble_ex,
    output logic       bubble_mem,
    output logic       bubble_wb,
    output logic       flush,
    output logic       multi_done,
    output logic       busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_MULTI = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and occupancy counter register; reset lands in RUN with an idle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority resolution: exception beats bus wait beats multi-cycle beats load-use.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall      = 4'b0000;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        bubble_wb  = 1'b0;
        flush      = 1'b0;
        multi_done = 1'b0;
        busy       = 1'b0;
        if (rst) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            busy = (state_q != ST_RUN);
            if (except_req) begin
                flush   = 1'b1;
                state_d = ST_RUN;
                cnt_d   = '0;
            end else if (mem_stall_req) begin
                stall     = 4'b1111;
                bubble_wb = 1'b1;
            end else if (state_q == ST_MULTI) begin
                if (cnt_q != '0) begin
                    stall      = 4'b0111;
                    bubble_mem = 1'b1;
                    cnt_d      = cnt_q - CNT_W'(1);
                end else begin
                    multi_done = 1'b1;
                    state_d    = ST_RUN;
                end
            end else if (ex_multi_start) begin
                stall      = 4'b0111;
                bubble_mem = 1'b1;
                state_d    = ST_MULTI;
                cnt_d      = CNT_W'(MULTI_CYCLES - 2);
            end else if (id_stall_req) begin
                stall     = 4'b0011;
                bubble_ex = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    // Event counters advance on every cycle that holds or clears the pipe; they wrap freely.
    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (stall != 4'b0000) perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        if (flush)            perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
    end

    // Event counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with literal expectations plus a
// cycle-by-cycle behavioural model of the stall/flush sequencer.
module tb_pipe_ctrl;

    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_stall_req = 1'b1;
    logic       ex_multi_start = 1'b1;
    logic       mem_stall_req = 1'b1;
    logic       except_req = 1'b1;
    logic [3:0] stall;
    logic       bubble_ex, bubble_mem, bubble_wb, flush, multi_done, busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Packed view: {stall[3:0], bubble_ex, bubble_mem, bubble_wb, flush, multi_done, busy}
    logic [9:0] outv;
    assign outv = {stall, bubble_ex, bubble_mem, bubble_wb, flush, multi_done, busy};

    pipe_ctrl #(.MULTI_CYCLES(MC), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_stall_req   (id_stall_req),
        .ex_multi_start (ex_multi_start),
        .mem_stall_req  (mem_stall_req),
        .except_req     (except_req),
        .stall          (stall),
        .bubble_ex      (bubble_ex),
        .bubble_mem     (bubble_mem),
        .bubble_wb      (bubble_wb),
        .flush          (flush),
        .multi_done     (multi_done),
        .busy           (busy)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Behavioural model: an op is "in EX" with a count of cycles already spent there.
    bit         m_in_op    = 1'b0;
    int         m_spent    = 0;
    logic [31:0] m_stall_n = 32'd0;
    logic [31:0] m_flush_n = 32'd0;

    // Compare process: every negedge, derive the required outputs from the rules and check.
    always @(negedge clk) begin
        logic [3:0] e_stall;
        logic       e_bex, e_bmem, e_bwb, e_flush, e_done, e_busy;
        logic [9:0] expv;
        e_stall = 4'b0000;
        e_bex = 1'b0; e_bmem = 1'b0; e_bwb = 1'b0;
        e_flush = 1'b0; e_done = 1'b0; e_busy = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
        total++;
        if (perf_stall_cnt !== m_stall_n || perf_flush_cnt !== m_flush_n) begin
            bad++;
            $display("[TB] FAIL perf_counters: got stall=%0d flush=%0d, required stall=%0d flush=%0d",
                     perf_stall_cnt, perf_flush_cnt, m_stall_n, m_flush_n);
        end
`endif
        if (rst) begin
            m_in_op = 1'b0;
            m_spent = 0;
        end else begin
            e_busy = m_in_op;
            if (except_req) begin
                e_flush = 1'b1;
                m_in_op = 1'b0;
                m_spent = 0;
            end else if (mem_stall_req) begin
                e_stall = 4'b1111;
                e_bwb   = 1'b1;
            end else if (m_in_op) begin
                if (m_spent == MC - 1) begin
                    e_done  = 1'b1;
                    m_in_op = 1'b0;
                    m_spent = 0;
                end else begin
                    e_stall = 4'b0111;
                    e_bmem  = 1'b1;
                    m_spent = m_spent + 1;
                end
            end else if (ex_multi_start) begin
                e_stall = 4'b0111;
                e_bmem  = 1'b1;
                m_in_op = 1'b1;
                m_spent = 1;
            end else if (id_stall_req) begin
                e_stall = 4'b0011;
                e_bex   = 1'b1;
            end
        end
        if (rst) begin
            m_stall_n = 32'd0;
            m_flush_n = 32'd0;
        end else begin
            if (e_stall != 4'b0000) m_stall_n = m_stall_n + 32'd1;
            if (e_flush)            m_flush_n = m_flush_n + 32'd1;
        end
        expv = {e_stall, e_bex, e_bmem, e_bwb, e_flush, e_done, e_busy};
        total++;
        if (outv !== expv) begin
            bad++;
            $display("[TB] FAIL model_cycle t=%0t: got %b, required %b", $time, outv, expv);
        end
    end

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic applyStimulus(input bit r, input bit id, input bit mul,
                                 input bit mem, input bit exc);
        @(posedge clk);
        #1;
        rst            = r;
        id_stall_req   = id;
        ex_multi_start = mul;
        mem_stall_req  = mem;
        except_req     = exc;
    endtask

    // Check the current cycle's outputs against a hand-computed literal.
    task automatic checkOutput(input string name, input logic [9:0] expv);
        @(negedge clk);
        total++;
        if (outv !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %b, required %b", name, outv, expv);
        end
    endtask

    // Directed scenarios followed by a model-checked pseudo-random tail.
    initial begin
        // Reset held 3 cycles with every request high.
        checkOutput("rst_c0", 10'b0000_000_000);
        applyStimulus(1, 1, 1, 1, 1); checkOutput("rst_c1", 10'b0000_000_000);
        applyStimulus(1, 1, 1, 1, 1); checkOutput("rst_c2", 10'b0000_000_000);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("idle_after_rst", 10'b0000_000_000);

        // Load-use pulse.
        applyStimulus(0, 1, 0, 0, 0); checkOutput("id_stall", 10'b0011_100_000);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("id_stall_after", 10'b0000_000_000);

        // Multi-cycle op, start held while in EX.
        applyStimulus(0, 0, 1, 0, 0); checkOutput("multi_c0", 10'b0111_010_000);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("multi_c1", 10'b0111_010_001);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("multi_c2", 10'b0111_010_001);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("multi_done", 10'b0000_000_011);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("multi_c4", 10'b0000_000_000);

        // Multi-cycle op stretched by a bus wait in its second cycle.
        applyStimulus(0, 0, 1, 0, 0); checkOutput("mstall_c0", 10'b0111_010_000);
        applyStimulus(0, 0, 1, 1, 0); checkOutput("mstall_c1", 10'b1111_001_001);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("mstall_c2", 10'b0111_010_001);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("mstall_c3", 10'b0111_010_001);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("mstall_done", 10'b0000_000_011);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("mstall_c5", 10'b0000_000_000);

        // Exception aborts an in-flight op.
        applyStimulus(0, 0, 1, 0, 0); checkOutput("abort_c0", 10'b0111_010_000);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("abort_c1", 10'b0111_010_001);
        applyStimulus(0, 0, 1, 0, 1); checkOutput("abort_flush", 10'b0000_000_101);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("abort_c3", 10'b0000_000_000);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("abort_c4", 10'b0000_000_000);

        // Exception beats every other request.
        applyStimulus(0, 1, 0, 1, 1); checkOutput("except_prio", 10'b0000_000_100);
        applyStimulus(0, 1, 1, 0, 1); checkOutput("except_vs_multi", 10'b0000_000_100);

        // Bus wait beats load-use; multi beats load-use.
        applyStimulus(0, 1, 0, 1, 0); checkOutput("mem_vs_id", 10'b1111_001_000);
        applyStimulus(0, 1, 1, 1, 0); checkOutput("mem_vs_multi", 10'b1111_001_000);
        applyStimulus(0, 1, 1, 0, 0); checkOutput("multi_vs_id", 10'b0111_010_000);
        applyStimulus(0, 1, 1, 0, 0); checkOutput("multi_ignores_id", 10'b0111_010_001);

        // Reset mid-op aborts it with no completion.
        applyStimulus(1, 0, 1, 0, 0); checkOutput("rst_mid_multi", 10'b0000_000_000);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("after_rst_mid", 10'b0000_000_000);
        applyStimulus(0, 0, 0, 0, 0); checkOutput("after_rst_mid2", 10'b0000_000_000);

        // Pseudo-random tail, checked only by the model process.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 19) == 0));
        end
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
